// File: rtl/uart_serial_decoder.sv
// rtl/uart_serial_decoder.sv - UART receive-side frame decoder on the APB clock
// Recovers start/5-8 data/optional parity/1-2 stop frames and emits one-cycle frame results.
module uart_serial_decoder #(
  parameter int DIV_W = 16
) (
  input  logic             pclk,
  input  logic             preset_n,
  input  logic             en,
  input  logic             uart_net,
  input  logic [DIV_W-1:0] bit_div,
  input  logic [1:0]       data_len,
  input  logic             parity_en,
  input  logic             parity_odd,
  input  logic             stop2,
  output logic             frame_valid,
  output logic [7:0]       frame_data,
  output logic             parity_err,
  output logic             frame_err,
  output logic             break_det,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_HIGH
  } state_t;

  state_t           state, state_d;
  logic             rx_meta, rx_s, rx_prev;
  logic [DIV_W-1:0] cnt, div_l, div_eff;
  logic [1:0]       len_l;
  logic             par_en_l, par_odd_l, stop2_l;
  logic [7:0]       shreg, data_aligned;
  logic [2:0]       bit_cnt;
  logic             par_bit, perr_acc, ferr_acc;
  logic             fall, tick, finish, ferr_final;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_net;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign fall    = rx_prev & ~rx_s;
  assign tick    = (cnt == DIV_W'(1));
  assign div_eff = (bit_div < DIV_W'(4)) ? DIV_W'(4) : bit_div;
  // Bits arrive at the top of shreg; shift short frames down to bit 0.
  assign data_aligned = shreg >> (2'd3 - len_l);
  assign ferr_final   = ferr_acc | ~rx_s;
  assign busy         = (state != IDLE);

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) state <= IDLE;
    else           state <= state_d;
  end

  always_comb begin
    state_d = state;
    finish  = 1'b0;
    case (state)
      IDLE:      if (fall) state_d = START;
      START:     if (tick) state_d = rx_s ? IDLE : DATA;
      DATA:      if (tick && bit_cnt == ({1'b0, len_l} + 3'd4))
                   state_d = par_en_l ? PARITY : STOP1;
      PARITY:    if (tick) state_d = STOP1;
      STOP1: begin
        if (tick) begin
          if (stop2_l) begin
            state_d = STOP2;
          end else begin
            finish  = 1'b1;
            state_d = rx_s ? IDLE : WAIT_HIGH;
          end
        end
      end
      STOP2: begin
        if (tick) begin
          finish  = 1'b1;
          state_d = rx_s ? IDLE : WAIT_HIGH;
        end
      end
      WAIT_HIGH: if (rx_s) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    if (!en) begin
      state_d = IDLE;
      finish  = 1'b0;
    end
  end

  // Frame configuration is captured at the start edge and held for the whole frame.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      cnt       <= '0;
      div_l     <= DIV_W'(4);
      len_l     <= 2'd0;
      par_en_l  <= 1'b0;
      par_odd_l <= 1'b0;
      stop2_l   <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fall) begin
            cnt       <= div_eff >> 1;
            div_l     <= div_eff;
            len_l     <= data_len;
            par_en_l  <= parity_en;
            par_odd_l <= parity_odd;
            stop2_l   <= stop2;
          end else begin
            cnt <= '0;
          end
        end
        WAIT_HIGH: cnt <= '0;
        default: begin
          if (tick)                  cnt <= div_l;
          else if (cnt > DIV_W'(1))  cnt <= cnt - DIV_W'(1);
        end
      endcase
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      shreg    <= 8'h00;
      bit_cnt  <= 3'd0;
      par_bit  <= 1'b0;
      perr_acc <= 1'b0;
      ferr_acc <= 1'b0;
    end else if (en) begin
      if (state == IDLE && fall) begin
        shreg    <= 8'h00;
        bit_cnt  <= 3'd0;
        par_bit  <= 1'b0;
        perr_acc <= 1'b0;
        ferr_acc <= 1'b0;
      end else if (tick) begin
        case (state)
          DATA: begin
            shreg   <= {rx_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          PARITY: begin
            par_bit  <= rx_s;
            perr_acc <= rx_s ^ (^data_aligned) ^ par_odd_l;
          end
          STOP1, STOP2: if (!rx_s) ferr_acc <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      frame_valid <= 1'b0;
      frame_data  <= 8'h00;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      break_det   <= 1'b0;
    end else begin
      frame_valid <= finish;
      if (finish) begin
        frame_data <= data_aligned;
        parity_err <= perr_acc;
        frame_err  <= ferr_final;
        break_det  <= ferr_final & (data_aligned == 8'h00) & ~(par_en_l & par_bit);
      end
    end
  end

endmodule

// File: tb/tb_uart_serial_decoder.sv
// tb/tb_uart_serial_decoder.sv - self-checking bench for uart_serial_decoder
// Frames are built bit-by-bit on the line; expected results come from the frame rules.
module tb_uart_serial_decoder;

  logic        pclk = 1'b0;
  logic        preset_n, en, uart_net;
  logic [15:0] bit_div;
  logic [1:0]  data_len;
  logic        parity_en, parity_odd, stop2;
  logic        frame_valid, parity_err, frame_err, break_det, busy;
  logic [7:0]  frame_data;

  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic       pe;
    logic       fe;
    logic       bk;
  } frame_t;

  frame_t obs[$];
  frame_t exp_q[$];
  int     cyc = 0;
  int     n_checks = 0;
  int     n_pass = 0;

  uart_serial_decoder #(.DIV_W(16)) dut (
    .pclk(pclk), .preset_n(preset_n), .en(en), .uart_net(uart_net),
    .bit_div(bit_div), .data_len(data_len), .parity_en(parity_en),
    .parity_odd(parity_odd), .stop2(stop2), .frame_valid(frame_valid),
    .frame_data(frame_data), .parity_err(parity_err), .frame_err(frame_err),
    .break_det(break_det), .busy(busy)
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk) cyc <= cyc + 1;

  always @(negedge pclk)
    if (frame_valid === 1'b1)
      obs.push_back('{cyc, frame_data, parity_err, frame_err, break_det});

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  // Drives one frame starting at the next falling clock edge; the line is left at the last bit.
  task automatic send_frame(input logic [7:0] d, input logic [1:0] dl, input logic pe,
                            input logic po, input logic s2, input int div,
                            input logic pflip, input logic st1, input logic st2);
    int         de, h, n, nb, t0;
    logic [7:0] dm;
    logic       x, par;
    logic       bits[$];
    frame_t     e;
    de = (div < 4) ? 4 : div;
    h  = de / 2;
    n  = int'(dl) + 5;
    dm = d & 8'((1 << n) - 1);
    x  = ^dm;
    par = x ^ po ^ pflip;
    bits.push_back(1'b0);
    for (int i = 0; i < n; i++) bits.push_back(d[i]);
    if (pe) bits.push_back(par);
    bits.push_back(st1);
    if (s2) bits.push_back(st2);
    nb = bits.size() - 1;
    @(negedge pclk);
    bit_div = 16'(div); data_len = dl; parity_en = pe; parity_odd = po; stop2 = s2;
    t0 = cyc;
    for (int b = 0; b < bits.size(); b++)
      for (int c = 0; c < de; c++) begin
        if (b != 0 || c != 0) @(negedge pclk);
        uart_net = bits[b];
      end
    e.cyc  = t0 + 3 + h + nb * de;
    e.data = dm;
    e.pe   = pe && (par != (po ? ~x : x));
    e.fe   = !st1 || (s2 && !st2);
    e.bk   = e.fe && (dm == 8'h00) && (!pe || !par);
    exp_q.push_back(e);
  endtask

  task automatic verify_frames(input string tag);
    int     n = 0;
    frame_t o, e;
    while (obs.size() < exp_q.size() && n < 4000) begin
      @(negedge pclk);
      n++;
    end
    repeat (4) @(negedge pclk);
    check({tag, " count"}, obs.size(), exp_q.size());
    while (exp_q.size() > 0 && obs.size() > 0) begin
      o = obs.pop_front();
      e = exp_q.pop_front();
      check({tag, " cycle"}, o.cyc, e.cyc);
      check({tag, " data"}, o.data, e.data);
      check({tag, " parity_err"}, o.pe, e.pe);
      check({tag, " frame_err"}, o.fe, e.fe);
      check({tag, " break_det"}, o.bk, e.bk);
    end
    obs.delete();
    exp_q.delete();
  endtask

  // Start bit plus a few data bits, leaving the decoder in DATA.
  task automatic drive_partial(input int cycles);
    @(negedge pclk);
    bit_div = 16'd8; data_len = 2'd3; parity_en = 1'b0; stop2 = 1'b0;
    uart_net = 1'b0;
    for (int c = 1; c < cycles; c++) begin
      @(negedge pclk);
      uart_net = ((c / 8) % 2 == 1);
    end
  endtask

  task automatic run_random(input int count);
    logic [7:0] d;
    logic [1:0] dl;
    logic       pe, po, s2, pf, st1, st2;
    int         div;
    for (int i = 0; i < count; i++) begin
      d   = 8'($urandom);
      dl  = 2'($urandom_range(0, 3));
      pe  = 1'($urandom);
      po  = 1'($urandom);
      s2  = 1'($urandom);
      pf  = ($urandom_range(0, 3) == 0);
      st1 = ($urandom_range(0, 5) != 0);
      st2 = ($urandom_range(0, 5) != 0);
      div = $urandom_range(2, 12);
      send_frame(d, dl, pe, po, s2, div, pf, st1, st2);
      if (uart_net == 1'b0) begin
        @(negedge pclk);
        uart_net = 1'b1;
        repeat (4) @(negedge pclk);
      end else begin
        repeat ($urandom_range(0, 3)) @(negedge pclk);
      end
    end
    verify_frames("random");
  endtask

  initial begin
    int t0;
    preset_n = 1'b0; en = 1'b1; uart_net = 1'b1;
    bit_div = 16'd8; data_len = 2'd3; parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
    repeat (3) @(negedge pclk);
    check("reset frame_valid", frame_valid, 1'b0);
    check("reset frame_data", frame_data, 8'h00);
    check("reset parity_err", parity_err, 1'b0);
    check("reset frame_err", frame_err, 1'b0);
    check("reset break_det", break_det, 1'b0);
    check("reset busy", busy, 1'b0);
    preset_n = 1'b1;
    repeat (3) @(negedge pclk);

    send_frame(8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 8, 1'b0, 1'b1, 1'b1);
    verify_frames("8N1 A5");

    send_frame(8'h13, 2'd0, 1'b1, 1'b1, 1'b1, 5, 1'b0, 1'b1, 1'b1);
    send_frame(8'h13, 2'd0, 1'b1, 1'b1, 1'b1, 5, 1'b1, 1'b1, 1'b1);
    verify_frames("5O2");

    send_frame(8'h41, 2'd2, 1'b1, 1'b0, 1'b0, 8, 1'b0, 1'b0, 1'b1);
    repeat (20) @(negedge pclk);
    check("wait_high busy", busy, 1'b1);
    uart_net = 1'b1;
    repeat (4) @(negedge pclk);
    check("wait_high release busy", busy, 1'b0);
    verify_frames("7E1 stop0");

    send_frame(8'h00, 2'd3, 1'b0, 1'b0, 1'b0, 8, 1'b0, 1'b0, 1'b0);
    repeat (16) @(negedge pclk);
    check("break busy", busy, 1'b1);
    uart_net = 1'b1;
    repeat (40) @(negedge pclk);
    verify_frames("break");

    @(negedge pclk);
    bit_div = 16'd8;
    uart_net = 1'b0;
    t0 = cyc;
    repeat (2) @(negedge pclk);
    uart_net = 1'b1;
    while (cyc < t0 + 3) @(negedge pclk);
    check("glitch busy high", busy, 1'b1);
    while (cyc < t0 + 7) @(negedge pclk);
    check("glitch busy low", busy, 1'b0);
    verify_frames("glitch");

    send_frame(8'h00, 2'd3, 1'b0, 1'b0, 1'b0, 8, 1'b0, 1'b1, 1'b1);
    send_frame(8'hFF, 2'd3, 1'b0, 1'b0, 1'b0, 8, 1'b0, 1'b1, 1'b1);
    verify_frames("back2back");

    drive_partial(40);
    en = 1'b0;
    @(negedge pclk);
    check("en abort busy", busy, 1'b0);
    uart_net = 1'b1;
    repeat (4) @(negedge pclk);
    en = 1'b1;
    repeat (100) @(negedge pclk);
    verify_frames("en abort");

    drive_partial(40);
    preset_n = 1'b0;
    #1;
    check("rst abort busy", busy, 1'b0);
    check("rst abort data", frame_data, 8'h00);
    uart_net = 1'b1;
    repeat (3) @(negedge pclk);
    preset_n = 1'b1;
    repeat (100) @(negedge pclk);
    verify_frames("rst abort");

    send_frame(8'h5A, 2'd3, 1'b0, 1'b0, 1'b0, 8, 1'b0, 1'b1, 1'b1);
    verify_frames("clean 5A");

    fork
      send_frame(8'hC3, 2'd3, 1'b0, 1'b0, 1'b0, 8, 1'b0, 1'b1, 1'b1);
      begin
        repeat (30) @(negedge pclk);
        bit_div = 16'd13;
      end
    join
    verify_frames("div change");

    run_random(40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish, got %0d checks expected completion", n_checks);
    $fatal(1);
  end

endmodule
